fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 134 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO, one frame per word.
// Frame: start bit, W data bits LSB first, optional parity bit, STOP_BITS stop bits.
module fifo_uart_tx #(
  parameter int W            = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_fifo_empty,
  input  logic [W-1:0] i_fifo_data,
  output logic         o_fifo_rd,
  input  logic         i_enable,
  output logic         o_tx,
  output logic         o_busy,
  output logic         o_sent,
  output logic [2:0]   dbg_state
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(W - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic PAR_ODD   = (PARITY == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [NW-1:0] bit_cnt;
  logic          stop_cnt;
  logic [W-1:0]  shreg;
  logic          par_bit;
  logic          bit_end;

  // Pop handshake: the head word is valid whenever i_fifo_empty is low; a
  // cycle with o_fifo_rd high both consumes it upstream and latches it here.
  assign o_fifo_rd = (state == S_IDLE) && i_enable && !i_fifo_empty && !i_reset;
  assign o_busy    = (state != S_IDLE);
  assign bit_end   = (baud == BAUD_LAST);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      o_tx     <= 1'b1;
      o_sent   <= 1'b0;
    end else begin
      o_sent <= 1'b0;
      case (state)
        S_IDLE: begin
          if (o_fifo_rd) begin
            shreg   <= i_fifo_data;
            par_bit <= (^i_fifo_data) ^ PAR_ODD;
            baud    <= '0;
            o_tx    <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            o_tx    <= shreg[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_cnt == BIT_LAST) begin
              if (PARITY != 0) begin
                o_tx  <= par_bit;
                state <= S_PARITY;
              end else begin
                o_tx     <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              // o_tx is registered, so it takes the bit that becomes LSB after this shift
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              o_tx    <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            baud     <= '0;
            o_tx     <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= S_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (stop_cnt == STOP_LAST) begin
              o_sent <= 1'b1;
              state  <= S_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          o_tx  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four configurations share one FIFO model; a per-instance
// monitor rebuilds every frame cycle-by-cycle and compares it to the scoreboard entry.
module tb_fifo_uart_tx;

  localparam int W   = 8;
  localparam int CPB = 4;

  logic            clk;
  logic            rst;
  logic            fifo_empty;
  logic [W-1:0]    fifo_data;
  logic [3:0]      en;
  logic [3:0]      rd;
  logic [3:0]      tx;
  logic [3:0]      busy;
  logic [3:0]      sent;
  logic [3:0][2:0] st;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic         pop_now;
  int           n_vec = 0;
  int           n_err = 0;

  fifo_uart_tx #(.W(W), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .i_reset(rst), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rd(rd[0]), .i_enable(en[0]), .o_tx(tx[0]), .o_busy(busy[0]),
    .o_sent(sent[0]), .dbg_state(st[0]));

  fifo_uart_tx #(.W(W), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .i_reset(rst), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rd(rd[1]), .i_enable(en[1]), .o_tx(tx[1]), .o_busy(busy[1]),
    .o_sent(sent[1]), .dbg_state(st[1]));

  fifo_uart_tx #(.W(W), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .i_reset(rst), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rd(rd[2]), .i_enable(en[2]), .o_tx(tx[2]), .o_busy(busy[2]),
    .o_sent(sent[2]), .dbg_state(st[2]));

  fifo_uart_tx #(.W(W), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .i_reset(rst), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rd(rd[3]), .i_enable(en[3]), .o_tx(tx[3]), .o_busy(busy[3]),
    .o_sent(sent[3]), .dbg_state(st[3]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void fifo_drive();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'hEE : fifo_q[0];
  endfunction

  task automatic push_word(input logic [W-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    fifo_drive();
  endtask

  // FIFO model: a pop seen in the cycle removes the head right after the edge
  initial begin
    forever begin
      @(negedge clk);
      pop_now = |rd;
      @(posedge clk);
      #1;
      if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_drive();
    end
  end

  task automatic monitor(input int idx, input int par, input int stops);
    logic [W-1:0] d;
    logic [15:0]  bit_seq;
    logic [63:0]  exp_tx, obs_tx;
    int           len, busy_n;
    logic         sent_seen, rd_seen, aborted;
    @(negedge clk);
    forever begin
      if (rd[idx] === 1'b1) begin
        check("pop_expected", 64'(exp_q.size() > 0), 64'd1);
        d = 8'h00;
        if (exp_q.size() > 0) d = exp_q.pop_front();
        bit_seq = '1;
        bit_seq[0] = 1'b0;
        for (int i = 0; i < W; i++) bit_seq[1+i] = d[i];
        if (par != 0) bit_seq[1+W] = (^d) ^ (par == 2);
        len = (1 + W + ((par != 0) ? 1 : 0) + stops) * CPB;
        exp_tx = '0;
        obs_tx = '0;
        for (int k = 0; k < len; k++) exp_tx[k] = bit_seq[k / CPB];
        busy_n = 0; sent_seen = 1'b0; rd_seen = 1'b0; aborted = 1'b0;
        for (int k = 0; k < len; k++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          obs_tx[k] = tx[idx];
          busy_n += int'(busy[idx]);
          sent_seen |= sent[idx];
          rd_seen |= rd[idx];
        end
        if (aborted) begin
          check("rst_mid_tx", 64'(tx[idx]), 64'd1);
          check("rst_mid_busy", 64'(busy[idx]), 64'd0);
          check("rst_mid_sent", 64'(sent[idx]), 64'd0);
          while (rst) @(negedge clk);
          check("rst_nosent", 64'(sent[idx]), 64'd0);
        end else begin
          check("frame_tx", obs_tx, exp_tx);
          check("busy_len", 64'(busy_n), 64'(len));
          check("sent_early", 64'(sent_seen), 64'd0);
          check("rd_midframe", 64'(rd_seen), 64'd0);
          @(negedge clk);
          check("sent_pulse", 64'(sent[idx]), 64'd1);
          check("idle_busy", 64'(busy[idx]), 64'd0);
          check("idle_tx", 64'(tx[idx]), 64'd1);
          check("rd_at_sent", 64'(rd[idx]), 64'(fifo_q.size() > 0 && en[idx]));
        end
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial monitor(0, 0, 1);
  initial monitor(1, 1, 1);
  initial monitor(2, 2, 1);
  initial monitor(3, 0, 2);

  // driver tasks
  task automatic wait_done(input int idx, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fifo_q.size() == 0 && busy[idx] == 1'b0 && sent[idx] == 1'b0 &&
                 rd[idx] == 1'b0) && n < budget);
    check("done_in_time", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_pop(input int idx, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd[idx] !== 1'b1 && n < budget);
    check("pop_seen", 64'(rd[idx]), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 4'b0000;
    fifo_drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 64'(tx), 64'hF);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_sent", 64'(sent), 64'h0);
    check("rst_rd", 64'(rd), 64'h0);
    check("rst_state", 64'(st), 64'h0);
    @(posedge clk); #2 rst = 1'b0;

    // enabled but FIFO empty
    en = 4'b0001;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("empty_rd", 64'(rd[0]), 64'd0);
    check("empty_busy", 64'(busy[0]), 64'd0);
    check("empty_tx", 64'(tx[0]), 64'd1);

    @(posedge clk); #2 push_word(8'hA5);
    wait_done(0, 200);

    // back-to-back frames
    @(posedge clk); #2 push_word(8'h00); push_word(8'hFF);
    wait_done(0, 300);

    // data waiting while disabled
    @(posedge clk); #2 en[0] = 1'b0; push_word(8'h5A);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("dis_rd", 64'(rd[0]), 64'd0);
    check("dis_busy", 64'(busy[0]), 64'd0);
    check("dis_tx", 64'(tx[0]), 64'd1);
    check("dis_fifo", 64'(fifo_q.size()), 64'd1);
    @(posedge clk); #2 en[0] = 1'b1;
    wait_done(0, 200);

    // enable dropped during START
    @(posedge clk); #2 push_word(8'h81); push_word(8'h42);
    wait_pop(0, 20);
    @(posedge clk); #2 en[0] = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk);
    check("hold_fifo", 64'(fifo_q.size()), 64'd1);
    check("hold_busy", 64'(busy[0]), 64'd0);
    check("hold_rd", 64'(rd[0]), 64'd0);
    @(posedge clk); #2 en[0] = 1'b1;
    wait_done(0, 200);

    // reset during data bit 3
    @(posedge clk); #2 push_word(8'h3C); push_word(8'hC3);
    wait_pop(0, 20);
    repeat (18) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_state", 64'(st[0]), 64'd0);
    check("rst_mid_rd", 64'(rd[0]), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_done(0, 200);

    // even parity
    @(posedge clk); #2 en = 4'b0010;
    push_word(8'h07);
    push_word(W'($urandom_range(0, 255)));
    wait_done(1, 300);

    // odd parity
    @(posedge clk); #2 en = 4'b0100;
    push_word(8'h03);
    push_word(W'($urandom_range(0, 255)));
    wait_done(2, 300);

    // two stop bits
    @(posedge clk); #2 en = 4'b1000;
    push_word(8'h55);
    push_word(W'($urandom_range(0, 255)));
    wait_done(3, 300);

    // random stream
    @(posedge clk); #2 en = 4'b0001;
    for (int i = 0; i < 6; i++) push_word(W'($urandom_range(0, 255)));
    wait_done(0, 800);
    check("exp_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
